// File: rtl/reset_sequencer.sv
// Reset bring-up sequencer: quiet period, global pulse, staggered stage release.
// Define RSTSEQ_HOLD_EN to add the `hold` input that stretches the pulse.
module reset_sequencer #(
  parameter int PRE_CYCLES   = 4,
  parameter int PULSE_CYCLES = 4,
  parameter int STAGES       = 3,
  parameter int GAP_CYCLES   = 2,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
`ifdef RSTSEQ_HOLD_EN
  input  logic              hold,
`endif
  output logic [STAGES-1:0] rst_out,
  output logic              busy,
  output logic              ready,
  output logic              done
);

  localparam int SW = $clog2(STAGES + 1);

  localparam logic [CNT_W-1:0] PRE_T =
    CNT_W'(PRE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_T =
    CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_T =
    CNT_W'(GAP_CYCLES - 1);
  localparam logic [SW-1:0] STG_LAST =
    SW'(STAGES - 1);
  localparam logic [STAGES-1:0] ONE =
    STAGES'(1);

  typedef enum logic [1:0] {
    S_PRE,
    S_PULSE,
    S_REL,
    S_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     stg_q, stg_d;
  logic [STAGES-1:0] rst_q, rst_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              freeze;

`ifdef RSTSEQ_HOLD_EN
  assign freeze = hold;
`else
  assign freeze = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stg_d   = stg_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_PRE: begin
        rst_d = '0;
        if (cnt_q == PRE_T) begin
          state_d = S_PULSE;
          cnt_d   = '0;
          rst_d   = '1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PULSE: begin
        // hold only stretches the pulse; it never skips ahead
        if (!freeze) begin
          if (cnt_q == PULSE_T) begin
            state_d = S_REL;
            cnt_d   = '0;
            stg_d   = '0;
            rst_d   = rst_q & ~ONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_REL: begin
        if (cnt_q == GAP_T) begin
          cnt_d = '0;
          if (stg_q == STG_LAST) begin
            state_d = S_RUN;
            rst_d   = '0;
            ready_d = 1'b1;
            done_d  = 1'b1;
          end else begin
            stg_d = stg_q + 1'b1;
            rst_d = rst_q & ~(ONE << stg_d);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RUN: begin
        rst_d = '0;
        if (req) begin
          state_d = S_PRE;
          cnt_d   = '0;
          stg_d   = '0;
          ready_d = 1'b0;
        end
      end
      default: begin
        state_d = S_PRE;
        cnt_d   = '0;
        stg_d   = '0;
        rst_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_PRE;
      cnt_q   <= '0;
      stg_q   <= '0;
      rst_q   <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stg_q   <= stg_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign rst_out = rst_q;
  assign ready   = ready_q;
  assign busy    = ~ready_q;
  assign done    = done_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default schedule, re-sequence,
// req filtering, async reset, minimal config and (optionally) hold.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req = 1'b0;
  logic       req1 = 1'b0;
  logic [2:0] rst0;
  logic       busy0, ready0, done0;
  logic [0:0] rst1;
  logic       busy1, ready1, done1;
`ifdef RSTSEQ_HOLD_EN
  logic       hold = 1'b0;
  logic       hold1 = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reset_sequencer u0 (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
`ifdef RSTSEQ_HOLD_EN
    .hold    (hold),
`endif
    .rst_out (rst0),
    .busy    (busy0),
    .ready   (ready0),
    .done    (done0)
  );

  reset_sequencer #(
    .PRE_CYCLES   (1),
    .PULSE_CYCLES (1),
    .STAGES       (1),
    .GAP_CYCLES   (1)
  ) u1 (
    .clk     (clk),
    .reset   (reset),
    .req     (req1),
`ifdef RSTSEQ_HOLD_EN
    .hold    (hold1),
`endif
    .rst_out (rst1),
    .busy    (busy1),
    .ready   (ready1),
    .done    (done1)
  );

  typedef struct {
    logic       req;
    logic [2:0] rst;
    logic       rdy;
    logic       dn;
  } vec_t;

  vec_t v [0:16];

  typedef struct {
    logic rst;
    logic rdy;
    logic dn;
  } vec1_t;

  vec1_t w [0:4];

  task automatic chk(input string nm, input int n,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               nm, n, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
  endtask

  task automatic run_table(input int last, input bit use_req,
                           input bit with_u1);
    for (int n = 0; n <= last; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      req = use_req ? v[n].req : 1'b0;
      chk("rst_out", n, 32'(rst0), 32'(v[n].rst));
      chk("ready", n, 32'(ready0), 32'(v[n].rdy));
      chk("busy", n, 32'(busy0), 32'(!v[n].rdy));
      chk("done", n, 32'(done0), 32'(v[n].dn));
      if (with_u1 && n <= 4) begin
        chk("u1_rst", n, 32'(rst1), 32'(w[n].rst));
        chk("u1_ready", n, 32'(ready1), 32'(w[n].rdy));
        chk("u1_done", n, 32'(done1), 32'(w[n].dn));
      end
    end
  endtask

  initial begin
    v[0]  = '{1'b0, 3'b000, 1'b0, 1'b0};
    v[1]  = '{1'b0, 3'b000, 1'b0, 1'b0};
    v[2]  = '{1'b1, 3'b000, 1'b0, 1'b0};
    v[3]  = '{1'b1, 3'b000, 1'b0, 1'b0};
    v[4]  = '{1'b1, 3'b111, 1'b0, 1'b0};
    v[5]  = '{1'b1, 3'b111, 1'b0, 1'b0};
    v[6]  = '{1'b1, 3'b111, 1'b0, 1'b0};
    v[7]  = '{1'b1, 3'b111, 1'b0, 1'b0};
    v[8]  = '{1'b1, 3'b110, 1'b0, 1'b0};
    v[9]  = '{1'b1, 3'b110, 1'b0, 1'b0};
    v[10] = '{1'b1, 3'b100, 1'b0, 1'b0};
    v[11] = '{1'b1, 3'b100, 1'b0, 1'b0};
    v[12] = '{1'b1, 3'b000, 1'b0, 1'b0};
    v[13] = '{1'b0, 3'b000, 1'b0, 1'b0};
    v[14] = '{1'b0, 3'b000, 1'b1, 1'b1};
    v[15] = '{1'b0, 3'b000, 1'b1, 1'b0};
    v[16] = '{1'b0, 3'b000, 1'b1, 1'b0};

    w[0] = '{1'b0, 1'b0, 1'b0};
    w[1] = '{1'b1, 1'b0, 1'b0};
    w[2] = '{1'b0, 1'b0, 1'b0};
    w[3] = '{1'b0, 1'b1, 1'b1};
    w[4] = '{1'b0, 1'b1, 1'b0};

    // default schedule plus minimal-config instance
    do_reset();
    run_table(16, 1'b0, 1'b1);

    // one-cycle req in RUN replays the whole schedule
    req = 1'b1;
    @(posedge clk);
    #1 req = 1'b0;
    run_table(16, 1'b0, 1'b0);

    // req held outside RUN must not restart anything
    do_reset();
    run_table(16, 1'b1, 1'b0);
    req = 1'b0;

    // async reset mid-RELEASE
    do_reset();
    run_table(9, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst", 9, 32'(rst0), 32'h0);
    chk("async_busy", 9, 32'(busy0), 32'h1);
    chk("async_ready", 9, 32'(ready0), 32'h0);
    do_reset();
    run_table(16, 1'b0, 1'b0);

`ifdef RSTSEQ_HOLD_EN
    do_reset();
    for (int n = 0; n <= 18; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      hold = (n >= 5 && n <= 7);
      if (n == 4 || n == 10)
        chk("hold_rst", n, 32'(rst0), 32'h7);
      if (n == 11)
        chk("hold_rst", n, 32'(rst0), 32'h6);
      if (n == 16)
        chk("hold_ready", n, 32'(ready0), 32'h0);
      if (n == 17) begin
        chk("hold_ready", n, 32'(ready0), 32'h1);
        chk("hold_done", n, 32'(done0), 32'h1);
      end
    end
    hold = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
